// File: rtl/window_counter.sv
// Per-window event counter with a result FIFO that flags a dropped result.
// Define WINDOW_COUNTER_TIMESTAMP_EN to store a window index with each result.
module window_counter #(
  parameter int COUNT_W      = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int WINDOW_IDX_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_cg,
  input  logic                    i_strobe,
  input  logic                    i_event,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [COUNT_W-1:0]      o_count,
  output logic                    o_countSat,
  output logic [WINDOW_IDX_W-1:0] o_windowIdx,
  output logic                    o_overflow,
  input  logic                    i_clearOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [COUNT_W-1:0]    acc;
  logic                  sat;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [COUNT_W-1:0]    cnt_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] sat_mem;

  logic                  close;
  logic                  hit;
  logic [COUNT_W-1:0]    acc_inc;
  logic [COUNT_W-1:0]    close_count;
  logic                  close_sat;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // An increment "hits" saturation when it lands on or would pass the max value.
  always_comb begin
    close       = i_cg && i_strobe;
    hit         = (acc >= (CNT_MAX - COUNT_W'(1)));
    acc_inc     = (acc == CNT_MAX) ? acc : acc + COUNT_W'(1);
    close_count = i_event ? acc_inc : acc;
    close_sat   = sat | (i_event & hit);
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop         = i_cg && !empty && i_ready;
    push        = close && (!full || pop);
    drop        = close && full && !pop;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      acc        <= '0;
      sat        <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else if (i_cg) begin
      if (close) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (i_event) begin
        acc <= acc_inc;
        sat <= sat | hit;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)                 o_overflow <= 1'b1;
      else if (i_clearOverflow) o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rstn && push) begin
      cnt_mem[wr_ptr[AW-1:0]] <= close_count;
      sat_mem[wr_ptr[AW-1:0]] <= close_sat;
    end
  end

  assign o_valid    = !empty;
  assign o_count    = o_valid ? cnt_mem[rd_ptr[AW-1:0]] : '0;
  assign o_countSat = o_valid ? sat_mem[rd_ptr[AW-1:0]] : 1'b0;

`ifdef WINDOW_COUNTER_TIMESTAMP_EN
  logic [WINDOW_IDX_W-1:0] win_idx;
  logic [WINDOW_IDX_W-1:0] idx_mem [FIFO_DEPTH];

  // The index advances on every close, so dropped windows leave a gap.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)    win_idx <= '0;
    else if (close) win_idx <= win_idx + WINDOW_IDX_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rstn && push) idx_mem[wr_ptr[AW-1:0]] <= win_idx;
  end

  assign o_windowIdx = o_valid ? idx_mem[rd_ptr[AW-1:0]] : '0;
`else
  assign o_windowIdx = '0;
`endif

endmodule

// File: tb/tb_window_counter.sv
// Directed bench for window_counter (COUNT_W=4, FIFO_DEPTH=4), either macro setting.
module tb_window_counter;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_cg;
  logic       i_strobe;
  logic       i_event;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_count;
  logic       o_countSat;
  logic [7:0] o_windowIdx;
  logic       o_overflow;
  logic       i_clearOverflow;

  int unsigned total = 0;
  int unsigned bad   = 0;

  window_counter #(
    .COUNT_W(4),
    .FIFO_DEPTH(4),
    .WINDOW_IDX_W(8)
  ) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .i_cg(i_cg),
    .i_strobe(i_strobe),
    .i_event(i_event),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_count(o_count),
    .o_countSat(o_countSat),
    .o_windowIdx(o_windowIdx),
    .o_overflow(o_overflow),
    .i_clearOverflow(i_clearOverflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_idx(input int v);
`ifdef WINDOW_COUNTER_TIMESTAMP_EN
    return 32'(v);
`else
    return 32'(0 * v);
`endif
  endfunction

  task automatic check_head(input string tag, input int cnt, input int sat, input int idx);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_count"}, 32'(o_count), 32'(cnt));
    check({tag, "_sat"}, 32'(o_countSat), 32'(sat));
    check({tag, "_idx"}, 32'(o_windowIdx), exp_idx(idx));
  endtask

  int exp_cnt [4] = '{1, 2, 3, 3};
  int exp_ix  [4] = '{1, 2, 3, 5};

  initial begin
    i_rstn = 1'b0; i_cg = 1'b1; i_strobe = 1'b0; i_event = 1'b0;
    i_ready = 1'b0; i_clearOverflow = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_sat", 32'(o_countSat), 32'd0);
    check("rst_idx", 32'(o_windowIdx), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    i_rstn = 1'b1;

    // five events, then a bare strobe
    i_event = 1'b1; repeat (5) tick();
    i_event = 1'b0; i_strobe = 1'b1; tick(); i_strobe = 1'b0;
    check_head("w5", 5, 0, 0);
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    check("w5_popped", 32'(o_valid), 32'd0);

    // saturation including a same-cycle closing event, then a short window
    i_event = 1'b1; repeat (20) tick();
    i_strobe = 1'b1; tick(); i_strobe = 1'b0;
    check_head("sat", 15, 1, 1);
    repeat (3) tick();
    i_event = 1'b0; i_strobe = 1'b1; tick(); i_strobe = 1'b0;
    check_head("sat_hold", 15, 1, 1);
    i_ready = 1'b1; tick();
    check_head("w3", 3, 0, 2);
    tick(); i_ready = 1'b0;
    check("w3_popped", 32'(o_valid), 32'd0);

    // five closes into a four-deep FIFO with no consumer
    i_rstn = 1'b0; tick(); i_rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_event = 1'b1; repeat (k) tick();
      i_event = 1'b0; i_strobe = 1'b1; tick(); i_strobe = 1'b0;
      if (k == 3) check("ovf_before", 32'(o_overflow), 32'd0);
    end
    check("ovf_after", 32'(o_overflow), 32'd1);
    check_head("full_head", 0, 0, 0);
    i_clearOverflow = 1'b1; tick(); i_clearOverflow = 1'b0;
    check("ovf_clear", 32'(o_overflow), 32'd0);

    // full FIFO: pop and push in the same cycle
    i_event = 1'b1; repeat (2) tick();
    i_strobe = 1'b1; i_ready = 1'b1; tick();
    i_strobe = 1'b0; i_ready = 1'b0; i_event = 1'b0;
    check("pp_ovf", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), exp_cnt[i], 0, exp_ix[i]);
      i_ready = 1'b1; tick(); i_ready = 1'b0;
    end
    check("drain_empty", 32'(o_valid), 32'd0);

    // clock gate low: everything ignored
    i_event = 1'b1; tick();
    i_event = 1'b0; i_strobe = 1'b1; tick(); i_strobe = 1'b0;
    i_event = 1'b1; tick(); tick();
    i_cg = 1'b0; i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_strobe = (i % 2) == 1;
      tick();
    end
    check_head("cg_hold", 1, 0, 6);
    i_cg = 1'b1; i_ready = 1'b0; i_event = 1'b0; i_strobe = 1'b1; tick(); i_strobe = 1'b0;
    check_head("cg_head", 1, 0, 6);
    i_ready = 1'b1; tick(); i_ready = 1'b0;
    check_head("cg_acc", 2, 0, 7);

    // reset mid-window with the gate low
    i_event = 1'b1; tick(); tick();
    i_cg = 1'b0; i_rstn = 1'b0; tick();
    check("mid_valid", 32'(o_valid), 32'd0);
    check("mid_count", 32'(o_count), 32'd0);
    check("mid_sat", 32'(o_countSat), 32'd0);
    check("mid_idx", 32'(o_windowIdx), 32'd0);
    check("mid_ovf", 32'(o_overflow), 32'd0);
    i_rstn = 1'b1; i_cg = 1'b1; i_event = 1'b0; i_strobe = 1'b1; tick(); i_strobe = 1'b0;
    check_head("post_rst", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
